jt6295_adpcm_dec: RTL and testbench

Time-multiplexed OKI ADPCM decoder and mixer that consumes the serialized nibble stream produced by the jt6295 channel scheduler (pipe_en / pipe_att / pipe_data plus the channel-0 `zero` marker). For each of the four channel slots it holds the predictor signal and step index, and decodes one nibble per `cen4` strobe. It applies the per-channel attenuation and sums the four channels into one signed sample per frame for the output filter stage.

---
 rtl/jt6295_adpcm_dec.sv | 79 +++++++
 tb/tb_jt6295_adpcm_dec.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/jt6295_adpcm_dec.sv
// jt6295_adpcm_dec: time-multiplexed 4-channel OKI ADPCM decoder with attenuation and mixing
// The channel state ring rotates every cen4 so the head always belongs to the current slot.
module jt6295_adpcm_dec (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen4,
    input  logic               zero,
    input  logic               pipe_en,
    input  logic [3:0]         pipe_att,
    input  logic [3:0]         pipe_data,
    output logic signed [13:0] sound,
    output logic               sample
);
    localparam logic [10:0] STEP [49] = '{
        11'd16, 11'd17, 11'd19, 11'd21, 11'd23, 11'd25, 11'd28, 11'd31, 11'd34, 11'd37,
        11'd41, 11'd45, 11'd50, 11'd55, 11'd60, 11'd66, 11'd73, 11'd80, 11'd88, 11'd97,
        11'd107, 11'd118, 11'd130, 11'd143, 11'd157, 11'd173, 11'd190, 11'd209, 11'd230, 11'd253,
        11'd279, 11'd307, 11'd337, 11'd371, 11'd408, 11'd449, 11'd494, 11'd544, 11'd598, 11'd658,
        11'd724, 11'd796, 11'd876, 11'd963, 11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552};
    localparam logic [5:0] GAIN [16] = '{
        6'd32, 6'd23, 6'd16, 6'd11, 6'd8, 6'd6, 6'd4, 6'd3, 6'd2,
        6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};

    logic signed [11:0] sig_r [4];
    logic        [5:0]  idx_r [4];
    logic signed [12:0] creg;
    logic signed [13:0] acc;
    logic        [14:0] prod;
    logic signed [13:0] sext, dx, sum;
    logic        [7:0]  adj, ix;
    logic signed [11:0] sig_n;
    logic        [5:0]  idx_n;
    logic signed [18:0] sig_x, gain_x, att_p;
    logic signed [12:0] contrib;
    logic signed [13:0] mix;

    always_comb begin
        prod    = 15'({pipe_data[2:0], 1'b1}) * 15'(STEP[idx_r[0]]);
        sext    = {{2{sig_r[0][11]}}, sig_r[0]};
        dx      = {2'b0, prod[14:3]};
        sum     = pipe_data[3] ? sext - dx : sext + dx;
        adj     = pipe_data[2] ? {4'b0, 3'(pipe_data[1:0]) + 3'd1, 1'b0} : 8'hFF;
        ix      = {2'b0, idx_r[0]} + adj;
        sig_n   = !pipe_en ? 12'sd0 : sum > 14'sd2047 ? 12'sh7FF : sum < -14'sd2048 ? 12'sh800 : sum[11:0];
        idx_n   = !pipe_en ? 6'd0 : ix[7] ? 6'd0 : ix > 8'd48 ? 6'd48 : ix[5:0];
        sig_x   = {{7{sig_n[11]}}, sig_n};
        gain_x  = {13'b0, GAIN[pipe_att]};
        att_p   = sig_x * gain_x;
        contrib = att_p[17:5];
        mix     = acc + {creg[12], creg};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                sig_r[i] <= '0;
                idx_r[i] <= '0;
            end
            creg   <= '0;
            acc    <= '0;
            sound  <= '0;
            sample <= 1'b0;
        end else begin
            sample <= cen4 & zero;
            if (cen4) begin
                for (int i = 0; i < 3; i++) begin
                    sig_r[i] <= sig_r[i+1];
                    idx_r[i] <= idx_r[i+1];
                end
                sig_r[3] <= sig_n;
                idx_r[3] <= idx_n;
                creg     <= contrib;
                acc      <= zero ? 14'sd0 : mix;
                if (zero)
                    sound <= mix;
            end
        end
    end
endmodule

// File: tb/tb_jt6295_adpcm_dec.sv
// tb_jt6295_adpcm_dec: directed frames against a behavioural decoder model with a sound scoreboard
module tb_jt6295_adpcm_dec;
    localparam int STEP [49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,
        107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,598,658,
        724,796,876,963,1060,1166,1282,1411,1552};
    localparam int GAIN [16] = '{32,23,16,11,8,6,4,3,2,0,0,0,0,0,0,0};

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cen4 = 1'b0;
    logic               zero = 1'b0;
    logic               pipe_en = 1'b0;
    logic [3:0]         pipe_att = '0;
    logic [3:0]         pipe_data = '0;
    logic signed [13:0] sound;
    logic               sample;

    int total = 0;
    int bad = 0;
    int ms [4];
    int mi [4];
    int mp, macc, mcreg;
    int q [$];

    jt6295_adpcm_dec dut (
        .clk(clk), .rst_n(rst_n), .cen4(cen4), .zero(zero), .pipe_en(pipe_en),
        .pipe_att(pipe_att), .pipe_data(pipe_data), .sound(sound), .sample(sample));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            ms[i] = 0;
            mi[i] = 0;
        end
        mp = 0;
        macc = 0;
        mcreg = 0;
    endtask

    // Reference: mixer consumes the previous slot's contribution before this slot decodes.
    task automatic model_strobe(input logic en, input logic [3:0] att, input logic [3:0] data, input logic z);
        int s, i, d, m;
        if (z) begin
            q.push_back(macc + mcreg);
            macc = 0;
        end else
            macc += mcreg;
        if (en) begin
            m = int'(data[2:0]);
            d = ((2 * m + 1) * STEP[mi[mp]]) >> 3;
            s = data[3] ? ms[mp] - d : ms[mp] + d;
            s = s > 2047 ? 2047 : s < -2048 ? -2048 : s;
            i = mi[mp] + (m < 4 ? -1 : 2 * (m - 3));
            i = i < 0 ? 0 : i > 48 ? 48 : i;
        end else begin
            s = 0;
            i = 0;
        end
        mcreg = (s * GAIN[att]) >>> 5;
        ms[mp] = s;
        mi[mp] = i;
        mp = (mp + 1) % 4;
    endtask

    task automatic strobe(input logic en, input logic [3:0] att, input logic [3:0] data, input logic z);
        pipe_en = en;
        pipe_att = att;
        pipe_data = data;
        zero = z;
        cen4 = 1'b1;
        model_strobe(en, att, data, z);
        @(posedge clk);
        #1;
        cen4 = 1'b0;
        zero = 1'b0;
        chk("sample_pulse", int'(sample), int'(z));
        if (z) begin
            if (q.size() == 0)
                chk("scoreboard_empty", 0, 1);
            else
                chk("sound_model", int'(sound), q.pop_front());
        end
        @(posedge clk);
        #1;
        chk("sample_one_cycle", int'(sample), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [3:0] en, input logic [15:0] att, input logic [15:0] data);
        for (int k = 0; k < 4; k++)
            strobe(en[k], att[4*k +: 4], data[4*k +: 4], k == 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        chk("rst_sound", int'(sound), 0);
        chk("rst_sample", int'(sample), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("por_sound", int'(sound), 0);
        repeat (3) frame(4'b0011, 16'h0000, 16'h0077);
        strobe(1'b1, 4'h0, 4'h7, 1'b1);
        strobe(1'b1, 4'h0, 4'h7, 1'b0);
        do_reset();
        repeat (2) frame(4'b0000, 16'h0000, 16'h0000);
        chk("idle_sound", int'(sound), 0);
        frame(4'b0001, 16'h0000, 16'h0000);
        frame(4'b0001, 16'h0000, 16'h0007);
        chk("pos_step_2", int'(sound), 2);
        frame(4'b0001, 16'h0000, 16'h0000);
        chk("pos_step_32", int'(sound), 32);
        do_reset();
        frame(4'b0001, 16'h0000, 16'h0008);
        frame(4'b0000, 16'h0000, 16'h0000);
        chk("sign_neg2", int'(sound), -2);
        repeat (10) frame(4'b0001, 16'h0000, 16'h0007);
        chk("sat_pos", int'(sound), 2047);
        repeat (10) frame(4'b0001, 16'h0000, 16'h000F);
        chk("sat_neg", int'(sound), -2048);
        repeat (6) frame(4'b0001, 16'h0000, 16'h0007);
        frame(4'b0001, 16'h0002, 16'h0007);
        frame(4'b0001, 16'h0008, 16'h0007);
        chk("att2", int'(sound), 1023);
        frame(4'b0001, 16'h0009, 16'h0007);
        chk("att8", int'(sound), 127);
        frame(4'b0001, 16'h000F, 16'h0007);
        chk("att9", int'(sound), 0);
        frame(4'b0001, 16'h000F, 16'h0007);
        chk("att15", int'(sound), 0);
        repeat (8) frame(4'b1111, 16'h0000, 16'h7777);
        chk("full_mix", int'(sound), 8188);
        frame(4'b1011, 16'h0000, 16'h7777);
        frame(4'b1011, 16'h0000, 16'h7777);
        chk("ch2_idle_mix", int'(sound), 6141);
        for (int i = 0; i < 20; i++)
            frame(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        frame(4'b0000, 16'h0000, 16'h0000);
        chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
